dmem_requester: RTL
===================

DMEM_REQUESTER -- requirements
Module: dmem_requester

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum cycles a memory request waits for mem_resp before aborting (legal range 1-65535).
REQ-002 clk  in  1  sole clock; all state SHALL update on posedge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  pipeline load/store request, sampled only in IDLE.
REQ-005 req_write  in  1  1 = store, 0 = load.
REQ-006 req_funct3  in  3  RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_wdata  in  32  store data, right-justified.
REQ-009 stall  out  1  high while a request is in flight and not yet done.
REQ-010 done  out  1  one-cycle pulse on completion.
REQ-011 load_data  out  32  extended load result, valid when done=1.
REQ-012 err  out  1  one-cycle pulse on timeout or misaligned trap.
REQ-013 mem_read  out  1  memory read strobe.
REQ-014 mem_write  out  1  memory write strobe.
REQ-015 mem_wmask  out  4  byte enables, bit i = byte lane i.
REQ-016 mem_address  out  32  word-aligned address (bits[1:0] = 00).
REQ-017 mem_wdata  out  32  lane-shifted store data.
REQ-018 mem_resp  in  1  memory response.
REQ-019 mem_rdata  in  32  memory read data, little-endian lanes.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, DONE; all memory-side outputs SHALL be registered.
REQ-021 IDLE + req_valid SHALL capture all req_* fields and go to ISSUE next cycle; req_valid=0 stays IDLE.
REQ-022 In ISSUE, mem_read (load) or mem_write (store) SHALL be held high with stable address/wmask/wdata until mem_resp=1 is sampled.
REQ-023 On sampled mem_resp=1 in ISSUE: strobes SHALL drop next cycle, state goes DONE, load_data registered from mem_rdata.
REQ-024 DONE SHALL last exactly one cycle with done=1, then return to IDLE; a new req_valid is accepted only in IDLE (one cycle after DONE).
REQ-025 Latency: req_valid at edge N -> strobe high after N -> earliest mem_resp at N+2 -> done=1 at N+3.
REQ-026 stall SHALL equal (state==ISSUE) OR (state==IDLE AND req_valid); stall=0 in DONE.
REQ-027 Store wmask: B = 0001<<addr[1:0], H = 0011<<addr[1:0], W = 1111; mem_wdata = req_wdata replicated per size (byte x4, half x2).
REQ-028 Load extraction: select byte/half by addr[1:0]; B/H sign-extend bit 7/15; BU/HU zero-extend; W pass-through.
REQ-029 Load wmask SHALL be 0000; undefined funct3 SHALL be treated as W.
REQ-030 A 16-bit wait counter SHALL clear on entering ISSUE and increment each ISSUE cycle; reaching TIMEOUT_CYCLES without mem_resp SHALL drop strobes, pulse err, go DONE with done=1 and load_data=0.
REQ-031 mem_resp in IDLE or DONE SHALL be ignored.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, counter 0, and stall, done, err, mem_read, mem_write = 0, mem_wmask = 0000, mem_address, mem_wdata, load_data = 0.
REQ-033 Reset mid-ISSUE SHALL drop strobes asynchronously; no done pulse follows.

Configuration
REQ-034 With MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=00 SHALL issue no memory access, go IDLE -> DONE directly, pulse err and done, load_data=0.
REQ-035 Without MISALIGN_TRAP_EN: misaligned H/W SHALL issue with addr[1:0] ignored (H lane from addr[1], W whole word); err only from timeout.

Verification
REQ-036 LW addr 0x100, mem_rdata 0xDEADBEEF, resp next cycle -> mem_address 0x100, done at N+3, load_data 0xDEADBEEF.
REQ-037 LB addr 0x103, rdata 0x80112233 -> load_data 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF8011.
REQ-038 SB addr 0x101, wdata 0x000000AB -> mem_wmask 0010, mem_wdata 0xABABABAB, mem_write held until mem_resp.
REQ-039 TIMEOUT_CYCLES=4, mem_resp tied 0 -> strobe high 4 cycles, then err=1 and done=1 same cycle, load_data 0.
REQ-040 SW addr 0x102 with MISALIGN_TRAP_EN -> mem_write never asserted, err=1, done=1 one cycle after request.
REQ-041 rst_n low during ISSUE of LW -> mem_read 0 immediately, no done; post-reset LW completes normally.

Source files
------------

// File: rtl/dmem_requester_if.sv
// Pipeline-side and memory-side signal bundle for dmem_requester.
// master = the requester itself, slave = pipeline plus memory.
interface dmem_requester_if;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        err;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_resp, mem_rdata,
        output stall, done, load_data, err, mem_read, mem_write, mem_wmask, mem_address, mem_wdata
    );

    modport slave (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_resp, mem_rdata,
        input  stall, done, load_data, err, mem_read, mem_write, mem_wmask, mem_address, mem_wdata
    );
endinterface

// File: rtl/dmem_requester.sv
// RV32 load/store requester: IDLE -> ISSUE -> DONE with lane steering and a wait timeout.
// Define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them.
module dmem_requester #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic              clk,
    input logic              rst_n,
    dmem_requester_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] ld_q, ld_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    // Size comes from funct3[1:0]: 00 B, 01 H, anything else W (covers undefined codes).
    logic        req_is_b, req_is_h, req_is_w;
    logic [3:0]  req_mask;
    logic [31:0] req_wrep;
    logic        misalign;

    assign req_is_b = (bus.req_funct3[1:0] == 2'b00);
    assign req_is_h = (bus.req_funct3[1:0] == 2'b01);
    assign req_is_w = !req_is_b && !req_is_h;

    always_comb begin
        req_mask = 4'b1111;
        req_wrep = bus.req_wdata;
        if (req_is_b) begin
            req_mask = 4'b0001 << bus.req_addr[1:0];
            req_wrep = {4{bus.req_wdata[7:0]}};
        end else if (req_is_h) begin
            // Half lane follows addr[1] only, so an odd address never straddles lanes.
            req_mask = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            req_wrep = {2{bus.req_wdata[15:0]}};
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign misalign = (req_is_h && bus.req_addr[0]) || (req_is_w && (bus.req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic        rd_signed;
    logic [31:0] rd_ext;

    always_comb begin
        case (off_q)
            2'd0:    rd_byte = bus.mem_rdata[7:0];
            2'd1:    rd_byte = bus.mem_rdata[15:8];
            2'd2:    rd_byte = bus.mem_rdata[23:16];
            default: rd_byte = bus.mem_rdata[31:24];
        endcase
        rd_half   = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        rd_signed = !f3_q[2];
        case (f3_q[1:0])
            2'b00:   rd_ext = {{24{rd_signed & rd_byte[7]}}, rd_byte};
            2'b01:   rd_ext = {{16{rd_signed & rd_half[15]}}, rd_half};
            default: rd_ext = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        f3_d        = f3_q;
        off_d       = off_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        wmask_d     = wmask_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ld_d        = ld_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    f3_d  = bus.req_funct3;
                    off_d = bus.req_addr[1:0];
                    cnt_d = '0;
                    if (misalign) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        ld_d    = '0;
                    end else begin
                        state_d     = ISSUE;
                        mem_read_d  = !bus.req_write;
                        mem_write_d = bus.req_write;
                        wmask_d     = bus.req_write ? req_mask : 4'b0000;
                        addr_d      = {bus.req_addr[31:2], 2'b00};
                        wdata_d     = req_wrep;
                    end
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 16'd1;
                // A response on the final allowed cycle still counts as success.
                if (bus.mem_resp) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (mem_read_q) ld_d = rd_ext;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    err_d       = 1'b1;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    ld_d        = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            wmask_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ld_q        <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            wmask_q     <= wmask_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ld_q        <= ld_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.stall       = (state_q == ISSUE) || ((state_q == IDLE) && bus.req_valid);
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.load_data   = ld_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_wmask   = wmask_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_wdata   = wdata_q;
endmodule
